// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator datapath blocks.
package calc_pkg;

  localparam int unsigned DEF_IN_W   = 8;
  localparam int unsigned DEF_DIGITS = 3;
  localparam logic [3:0]  BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit cell: adds 3 to a BCD nibble that would overflow on the next shift.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/power_bcd_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
module power_bcd_conv
  import calc_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  input  logic                  sat_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf_out
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + IN_W;
  localparam int unsigned CNT_W = cnt_width(IN_W);

  state_t            state, state_nxt;
  logic [SR_W-1:0]   sreg;
  logic [SR_W-1:0]   sreg_adj;
  logic [CNT_W-1:0]  cnt;
  logic              sat_q;
  logic              accept_c;
  logic              last_c;
  logic              busy_nxt;
  logic              done_nxt;

  assign accept_c = (state == IDLE) && start;
  assign last_c   = (cnt == CNT_W'(IN_W - 1));

  // Adjust every BCD nibble before the shift; the binary field passes through.
  assign sreg_adj[IN_W-1:0] = sreg[IN_W-1:0];
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sreg[IN_W+4*g +: 4]),
      .dout (sreg_adj[IN_W+4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy spans accept through the DONE cycle; done marks the result update.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state)
      IDLE:    busy_nxt = start;
      SHIFT:   busy_nxt = 1'b1;
      DONE: begin
        busy_nxt = 1'b1;
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      cnt     <= '0;
      sat_q   <= 1'b0;
      bcd_out <= '0;
      ovf_out <= 1'b0;
    end else begin
      if (accept_c) begin
        sreg  <= {BCD_W'(0), bin_in};
        cnt   <= '0;
        sat_q <= sat_in;
      end
      if (state == SHIFT) begin
        sreg <= {sreg_adj[SR_W-2:0], 1'b0};
        if (!last_c) cnt <= cnt + CNT_W'(1);
      end
      // Outputs change only here, so no partial result is ever visible.
      if (state == DONE) begin
        bcd_out <= sat_q ? {DIGITS{BLANK_CODE}} : sreg[SR_W-1 -: BCD_W];
        ovf_out <= sat_q;
      end
    end
  end

endmodule

// File: tb/tb_power_bcd_conv.sv
// Directed bench for power_bcd_conv with an expected-result queue checked on each done pulse.
module tb_power_bcd_conv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        sat_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic        ovf_out;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [12:0] exp_q[$];

  power_bcd_conv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .sat_in  (sat_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf_out (ovf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result checker: each done pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        chk("bcd_out", 32'(bcd_out), 32'(e[11:0]));
        chk("ovf_out", 32'(ovf_out), 32'(e[12]));
      end
    end
  end

  // Reference double dabble by decimal division.
  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int unsigned x;
    x = int'(v);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic launch(input logic [7:0] v, input logic s);
    start  = 1'b1;
    bin_in = v;
    sat_in = s;
    exp_q.push_back(s ? {1'b1, 12'hFFF} : {1'b0, to_bcd(v)});
    tick();
    start = 1'b0;
  endtask

  // Tick until done, checking busy meanwhile; c counts edges since the accepting edge.
  task automatic wait_done(input int c0, input int exp_c, input string tag);
    int  c;
    bit  seen;
    c    = c0;
    seen = 1'b0;
    while (c < 40 && !seen) begin
      tick();
      c++;
      if (done) seen = 1'b1;
      else chk({tag, "_busy"}, 32'(busy), 32'(1));
    end
    chk({tag, "_latency"}, seen ? 32'(c) : 32'hFFFF_FFFF, 32'(exp_c));
  endtask

  task automatic after_done(input string tag);
    tick();
    chk({tag, "_done_drop"}, 32'(done), 32'(0));
    chk({tag, "_busy_drop"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int d0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    sat_in = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_bcd",  32'(bcd_out), 32'(0));
    chk("rst_ovf",  32'(ovf_out), 32'(0));
    rst_n = 1'b1;
    tick();

    // Zero input, busy from E0 through E9.
    launch(8'd0, 1'b0);
    chk("zero_busy_e0", 32'(busy), 32'(1));
    wait_done(0, 9, "zero");
    chk("zero_busy_e9", 32'(busy), 32'(1));
    after_done("zero");

    launch(8'd81, 1'b0);   wait_done(0, 9, "v81");  after_done("v81");
    launch(8'd128, 1'b0);  wait_done(0, 9, "v128"); after_done("v128");
    launch(8'd255, 1'b0);  wait_done(0, 9, "v255"); after_done("v255");

    // Saturated result blanks all digits, then a clean conversion clears ovf.
    launch(8'hFF, 1'b1);   wait_done(0, 9, "sat");  after_done("sat");
    launch(8'd9, 1'b0);    wait_done(0, 9, "v9");   after_done("v9");

    // Start while busy is ignored.
    d0 = done_cnt;
    launch(8'd64, 1'b0);
    repeat (3) tick();
    start  = 1'b1;
    bin_in = 8'd200;
    tick();
    start  = 1'b0;
    wait_done(4, 9, "v64");
    after_done("v64");
    repeat (4) tick();
    chk("ignored_start_one_done", 32'(done_cnt - d0), 32'(1));

    // Reset mid-conversion drops the in-flight value.
    d0     = done_cnt;
    start  = 1'b1;
    bin_in = 8'd99;
    sat_in = 1'b0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_bcd",  32'(bcd_out), 32'(0));
    repeat (12) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("midrst_no_done", 32'(done_cnt - d0), 32'(0));
    launch(8'd17, 1'b0);   wait_done(0, 9, "v17");  after_done("v17");

    // start held high: back-to-back conversions every 10 cycles.
    launch(8'd1, 1'b0);
    start  = 1'b1;
    bin_in = 8'd250;
    exp_q.push_back({1'b0, to_bcd(8'd250)});
    wait_done(0, 9, "held1");
    tick();
    start = 1'b0;
    chk("held_busy_e10", 32'(busy), 32'(1));
    wait_done(10, 19, "held2");
    after_done("held2");

    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/power_bcd_conv.md
Name: power_bcd_conv

Overview:
- Sequential binary-to-BCD converter sitting directly downstream of the Power stage.
- Takes the 8-bit result and an overflow qualifier, runs a shift-and-add-3 (double dabble) conversion over IN_W cycles, and presents registered BCD digits to the display driver.
- A start/busy/done handshake lets the calculator control FSM launch one conversion per new result.

Parameters:
- IN_W, 8, binary input width (matches the Power result width).
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^IN_W - 1.
- BLANK_CODE, 4'hF, code driven on every digit when the overflow qualifier is set.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin_in  input  IN_W  binary value from the Power stage.
- sat_in  input  1  overflow qualifier (Power saturated its output to all-ones).
- busy  output  1  high from the accepting edge until done drops.
- done  output  1  single-cycle pulse; output digits are valid and updated in that cycle.
- bcd_out  output  4*DIGITS  digits, most significant digit in the top nibble.
- ovf_out  output  1  registered copy of the sat_in captured at start.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; busy=0, done=0, ovf_out=0.
  - bcd_out=0; shift register and counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: capture bin_in into the low IN_W bits of a (4*DIGITS+IN_W)-bit shift register, with the BCD field cleared.
  - Capture sat_in into sat_q and clear the iteration counter. Next state SHIFT; busy=1.
- SHIFT:
  - Each edge: every 4-bit BCD field >= 5 gets +3 (combinational adjust), then the whole register shifts left by 1. Counter increments.
  - After the IN_W-th shift (counter == IN_W-1), next state DONE.
- DONE, one cycle:
  - If sat_q=0, bcd_out <= BCD field; otherwise every nibble of bcd_out <= BLANK_CODE.
  - ovf_out <= sat_q; done=1 for exactly this cycle. Next state IDLE; busy falls with done.
- Latency: start accepted at edge E0; shifts on E1..E8; done and bcd_out updated at E9 (IN_W+1 cycles). Next start can be accepted at E10.
- Output stability:
  - bcd_out and ovf_out hold their last values between conversions. They never show partial results.
- start while busy=1 (SHIFT or DONE): ignored, not queued. The bin_in change has no effect until the next accepted start.
- start held high continuously: a new conversion is accepted on every IDLE edge (back-to-back every IN_W+2 cycles).
- Reset asserted mid-conversion: immediate return to reset values. No done pulse; the in-flight value is lost.
- bin_in=0 yields all-zero digits; no leading-zero suppression (that belongs to the display stage).
- Counter width: clog2(IN_W); no wrap inside SHIFT beyond IN_W-1.

Decomposition:
- Shared package calc_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - DIGITS / IN_W defaults and BLANK_CODE.
  - Function to compute the counter width.
- Sub-module bcd_digit_adj: combinational 4-bit cell, out = (in >= 5) ? in + 3 : in. Instantiated DIGITS times by generate.

Test Plan:
- Reset then start with bin_in=8'd0, sat_in=0 -> done at E9, bcd_out=12'h000, ovf_out=0, busy high E0..E9.
- Start with bin_in=8'd81 (3^4) -> bcd_out=12'h081. Then bin_in=8'd128 (2^7) -> 12'h128. Then 8'd255 -> 12'h255.
- Start with bin_in=8'hFF, sat_in=1 -> bcd_out=12'hFFF, ovf_out=1. A following conversion of 8'd9, sat_in=0 -> 12'h009, ovf_out=0.
- Launch 8'd64; pulse start with bin_in=8'd200 at E4 -> ignored; result 12'h064; exactly one done pulse.
- Launch 8'd99; assert rst_n=0 at E5 -> busy=0, done never pulses, bcd_out=0. After release, convert 8'd17 -> 12'h017.
- start held high, inputs 8'd1 then 8'd250 -> done pulses 10 cycles apart with 12'h001 then 12'h250.
